mult_share_arbiter: RTL
=======================

# mult_share_arbiter

Round-robin arbiter and sequencer that shares one `combinational_multiplier` instance (unsigned W x W -> 2W) among NREQ requesters. Each requester raises a request with its operands. The block grants one requester, latches that requester's operands into the multiplier, and registers the product. It then presents the product with the requester's ID on a valid/ready result port. It sits between the arithmetic clients and the multiplier datapath, so there is only one multiplier in the design.

## Interface
- `NREQ`, 2: number of requesters, 2..8.
- `W`, 8: operand width. Must equal the `combinational_multiplier` operand width, which is 8.
- `IDW`, 3: requester ID width. Must satisfy 2^IDW >= NREQ.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `a_in`  in  NREQ*W  flattened operand A; requester i uses bits [i*W +: W].
- `b_in`  in  NREQ*W  flattened operand B, same packing as `a_in`.
- `gnt`  out  NREQ  one-hot, one-cycle grant pulse, registered.
- `busy`  out  1  high in any state other than IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_id`  out  IDW  index of the granted requester.
- `product`  out  2W  registered product.

## Operation
- FSM has three states: IDLE, MUL, DONE.
- **IDLE**
  - If `req` is nonzero, pick a winner by round-robin. Search starts at `ptr+1` and wraps modulo NREQ.
  - On the same edge: latch that requester's A and B into `op_a`/`op_b`, latch the winner into `cur_id`, set `gnt[winner]` for one cycle, set `ptr` to the winner, and go to MUL.
  - Otherwise stay in IDLE.
- **MUL**
  - The multiplier drives combinationally from `op_a`/`op_b`.
  - On the next edge: register the product into `product`, copy `cur_id` into `res_id`, set `res_valid`, and go to DONE.
- **DONE**
  - Hold `product`, `res_id` and `res_valid` stable until `res_valid & res_ready` is sampled.
  - On that edge: clear `res_valid` and go to IDLE.
  - No arbitration takes place in DONE or MUL. Requests are ignored, not queued.
- **Requester obligations**
  - Hold `req[i]` and its operands stable until `gnt[i]` is seen.
  - Drop or refresh `req[i]` in the cycle after `gnt[i]`. A still-high `req` is treated as a new request.
- **Arithmetic**
  - Unsigned product, exactly 2W bits, no overflow possible.
  - Operand values sampled at the grant edge are the only ones used. Later changes on `a_in`/`b_in` have no effect.
- **Fairness**: the winner becomes the lowest priority for the next arbitration. With all requesters persistently active, grants rotate 0, 1, ..., NREQ-1, 0.
- **Reset values** (asynchronous, effective immediately, including mid-MUL or mid-DONE):
  - state = IDLE, `gnt` = 0, `busy` = 0, `res_valid` = 0, `res_id` = 0, `product` = 0.
  - `op_a` = `op_b` = 0, `ptr` = NREQ-1, so requester 0 wins first.
  - Any in-flight operation is discarded with no result.

## Timing
- `req` sampled in IDLE at edge k:
  - `gnt` and `busy` go high after edge k.
  - `res_valid` goes high after edge k+1.
  - Minimum grant-to-result latency is 1 cycle. Minimum request-to-result latency is 2 edges.
- `res_ready` high while `res_valid` is high: accepted at that edge, back in IDLE after it. The earliest next grant is the following edge.
- Minimum issue interval is 3 cycles per product, with `res_ready` tied high.
- `res_ready` low stalls DONE indefinitely, with `product` and `res_id` held.
- `res_ready` is ignored when `res_valid` is low.
- `gnt` is never high for more than one cycle and never has more than one bit set.

## Structure
- Shared include `mult_ctrl_defs.vh`:
  - state localparams (IDLE=2'd0, MUL=2'd1, DONE=2'd2)
  - default W, NREQ and IDW constants.
- The round-robin winner search is natural as a sub-module, `rr_pick`:
  - combinational; inputs `req` and `ptr`; outputs `found` and `winner`.
  - Unit-testable on its own.
- The existing `combinational_multiplier` is instantiated once, unmodified.

## Test plan
- **Single request**: after reset, `req`=01, a0=4, b0=2.
  - `gnt`=01 one cycle later, then `res_valid`=1 with `product`=8 and `res_id`=0.
- **Simultaneous requests**: `req`=11, a0=12, b0=243, a1=255, b1=255, `res_ready`=1.
  - First result is `product`=2916 with `res_id`=0.
  - Second result is `product`=65025 with `res_id`=1.
- **Backpressure**: hold `res_ready`=0 for 4 cycles in DONE.
  - `product`, `res_id` and `res_valid` stay stable.
  - No `gnt` while `req1` is held.
  - Result is accepted on the first `res_ready`=1 edge.
- **Fairness**: both requesters persistently requesting.
  - Grants alternate 01, 10, 01, 10 over 4 operations.
  - Each result matches the operands sampled at its grant.
- **Reset mid-MUL**: assert `rst` the cycle after `gnt`.
  - All outputs go to 0 immediately and no `res_valid` appears.
  - After release, `req`=10 yields `res_id`=1.
- **Operand change after grant**: change a0 from 7 to 9 the cycle after `gnt`.
  - `product` reflects 7 x b0.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// mult_share_arbiter_pkg
//   Shared definitions for the multiplier-sharing arbiter: sequencer state
//   encoding and default sizing constants.
package mult_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The multiplier datapath is fixed at 8-bit operands.
    localparam int DEF_W    = 8;
    localparam int DEF_NREQ = 2;
    localparam int DEF_IDW  = 3;

endpackage

// File: rtl/combinational_multiplier.sv
// combinational_multiplier
//   Unsigned 8 x 8 -> 16 combinational multiplier.
//   a, b    : operands
//   product : full-width unsigned product
module combinational_multiplier (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    assign product = 16'(a) * 16'(b);

endmodule

// File: rtl/mult_share_arbiter_rr.sv
// rr_pick
//   Combinational round-robin winner search.
//   req    : request vector
//   ptr    : index of the last winner; search starts at ptr+1, wraps mod NREQ
//   found  : at least one request is set
//   winner : index of the first set request found in search order
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        // k runs 1..NREQ so the last winner (offset NREQ) is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational_multiplier among NREQ requesters. A winner is
//   picked round-robin in IDLE, its operands are latched, the product is
//   registered one cycle later and held on a valid/ready result port.
//   clk, rst         : clock, asynchronous active-high reset
//   req              : per-requester request level
//   a_in, b_in       : flattened operands, requester i at [i*W +: W]
//   gnt              : registered one-hot grant pulse (one cycle)
//   busy             : sequencer not in IDLE
//   res_valid/ready  : result handshake
//   res_id           : requester that owns the result
//   product          : registered 2W-bit unsigned product
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,     // must match the multiplier width (8)
    parameter int IDW  = DEF_IDW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [2*W-1:0]    product
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] mul_p;
    logic           found;
    logic [IDW-1:0] winner;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    combinational_multiplier u_mul (
        .a       (op_a),
        .b       (op_b),
        .product (mul_p)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            product   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cur_id    <= '0;
            // Last winner = NREQ-1 so requester 0 is searched first.
            ptr       <= IDW'(NREQ - 1);
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        op_a   <= a_in[int'(winner)*W +: W];
                        op_b   <= b_in[int'(winner)*W +: W];
                        cur_id <= winner;
                        ptr    <= winner;
                        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    product   <= mul_p;
                    res_id    <= cur_id;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Requests are not looked at here; they are re-arbitrated
                    // once back in IDLE.
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
